// File: rtl/bird_draw_engine.sv
// Bird sprite repaint engine: erases the sprite at the previous row, redraws it at the new row,
// and emits one pixel per clock to the VGA adapter. Optional macro: SKIP_UNCHANGED_EN.
module bird_draw_engine #(
  parameter logic [7:0] BIRD_X      = 8'd20,
  parameter int         BIRD_W      = 4,
  parameter int         BIRD_H      = 4,
  parameter logic [2:0] BG_COLOUR   = 3'b111,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [6:0] Y_MAX       = 7'd119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bird_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [3:0] COL_LAST = 4'(BIRD_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(BIRD_H - 1);
  localparam logic [7:0] START_Y  = 8'd60;

  state_t     state, state_nxt;
  logic [3:0] col, row, col_nxt, row_nxt;
  logic [7:0] old_y, new_y;
  logic [7:0] base_y, pix_y;
  logic       sweeping, last_pix, accept;

  assign sweeping = (state == ERASE) || (state == DRAW);
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  // done is registered, so the visible done cycle already sits in IDLE; hold off
  // a start there so the completion cycle ignores start as a whole.
  assign accept   = (state == IDLE) && start && !done;
  assign base_y   = (state == ERASE) ? old_y : new_y;
  assign pix_y    = base_y + {4'd0, row};

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    case (state)
      IDLE: begin
        if (accept) begin
          col_nxt = 4'd0;
          row_nxt = 4'd0;
`ifdef SKIP_UNCHANGED_EN
          state_nxt = (bird_y == old_y) ? DONE : ERASE;
`else
          state_nxt = ERASE;
`endif
        end
      end
      ERASE, DRAW: begin
        if (col == COL_LAST) begin
          col_nxt = 4'd0;
          row_nxt = row + 4'd1;
        end else begin
          col_nxt = col + 4'd1;
        end
        if (last_pix) begin
          row_nxt   = 4'd0;
          state_nxt = (state == ERASE) ? DRAW : DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      col    <= 4'd0;
      row    <= 4'd0;
      old_y  <= START_Y;
      new_y  <= 8'd0;
      x_out  <= 8'd0;
      y_out  <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      if (accept)
        new_y <= bird_y;
      if (state == DONE)
        old_y <= new_y;
      busy <= sweeping;
      done <= (state == DONE);
      // Off-screen rows still take their cycle; only the write enable is dropped.
      plot <= sweeping && (pix_y <= {1'b0, Y_MAX});
      if (sweeping) begin
        x_out  <= BIRD_X + {4'd0, col};
        y_out  <= pix_y[6:0];
        colour <= (state == ERASE) ? BG_COLOUR : BIRD_COLOUR;
      end
    end
  end

endmodule

// File: tb/tb_bird_draw_engine.sv
// Directed bench for bird_draw_engine: full repaint sweeps, clipping, ignored restarts,
// mid-sweep reset and the unchanged-row case.
module tb_bird_draw_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] bird_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  int checks = 0;
  int errors = 0;

  bird_draw_engine dut (
    .clk(clk), .reset(reset), .start(start), .bird_y(bird_y),
    .x_out(x_out), .y_out(y_out), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One repaint from old row oy to new row by; inj pulses start mid-draw and on the done cycle.
  task automatic frame(input logic [7:0] by, input logic [7:0] oy, input bit inj);
    logic [7:0] ey;
    int idx;
    bird_y = by;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (inj && k == 20) begin
        start  = 1'b1;
        bird_y = 8'd5;
      end
      if (inj && k == 21) start = 1'b0;
      idx = k % 16;
      ey  = ((k < 16) ? oy : by) + 8'(idx / 4);
      chk("x",      32'(x_out),  32'(20 + idx % 4));
      chk("y",      32'(y_out),  32'(ey[6:0]));
      chk("colour", 32'(colour), (k < 16) ? 32'h7 : 32'h6);
      chk("plot",   32'(plot),   32'(ey <= 8'd119));
      chk("busy",   32'(busy),   32'd1);
      chk("done",   32'(done),   32'd0);
    end
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd0);
    chk("done_plot",  32'(plot), 32'd0);
    if (inj) begin
      start  = 1'b1;
      bird_y = 8'd9;
    end
    step();
    start = 1'b0;
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_plot", 32'(plot), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bird_y = 8'd0;
    step();
    chk("rst_x",      32'(x_out),  32'd0);
    chk("rst_y",      32'(y_out),  32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    chk("rst_plot",   32'(plot),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    reset = 1'b0;
    step();

    frame(8'd64,  8'd60,  1'b0);
    frame(8'd70,  8'd64,  1'b0);
    frame(8'd118, 8'd70,  1'b0);
    frame(8'd50,  8'd118, 1'b1);

    // Reset lands during the 5th draw pixel; old row must fall back to 60.
    bird_y = 8'd90;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    frame(8'd80, 8'd60, 1'b0);

`ifdef SKIP_UNCHANGED_EN
    bird_y = 8'd80;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("skip_busy0", 32'(busy), 32'd0);
    chk("skip_done0", 32'(done), 32'd0);
    step();
    chk("skip_done",  32'(done), 32'd1);
    chk("skip_plot",  32'(plot), 32'd0);
    chk("skip_busy",  32'(busy), 32'd0);
    step();
    chk("skip_after", 32'(done), 32'd0);
`else
    frame(8'd80, 8'd80, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
